conv_stream_feeder: RTL

- AXI4-Stream slave that sits between the DMA MM2S channel and the 3x3 convolution core.
- Unpacks one frame per transfer: first a 3x3 signed weight set, then a padded (COLS+2)x(3*GROUPS+2) 8-bit image.
- Buffers 5 input rows in a rotating line store.
- For each row group, emits COLS back-to-back beats of five 24-bit horizontal pixel triples (pdata1..5).
- Those beats feed the core that produces 3 output rows per group.

---
 rtl/conv_stream_feeder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_stream_feeder.sv
// AXI4-Stream feeder for the 3x3 convolution core: unpacks a weight set, buffers five padded
// image rows in a rotating line store and emits COLS beats of five horizontal pixel triples.
`timescale 1ns/1ps
module conv_stream_feeder #(
    parameter int unsigned COLS      = 48,
    parameter int unsigned GROUPS    = 16,
    parameter int unsigned ROW_BEATS = (COLS + 2 + 3) / 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [71:0] wdata,
    output logic        wdata_valid,
    output logic [23:0] pdata1,
    output logic [23:0] pdata2,
    output logic [23:0] pdata3,
    output logic [23:0] pdata4,
    output logic [23:0] pdata5,
    output logic        pdata_valid,
    output logic        frame_done,
    output logic        err
);

    localparam int unsigned RowBytes = ROW_BEATS * 4;
    localparam int unsigned BeatW    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int unsigned ByteW    = BeatW + 2;
    localparam int unsigned ColW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned GrpW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {StWLoad, StRowLoad, StEmit, StFinish} state_e;

    state_e state_q, state_d;

    logic [1:0]       wcnt_q;
    logic [63:0]      wbuf_q;
    logic [BeatW-1:0] beat_cnt_q;
    logic [2:0]       wr_slot_q;
    logic [2:0]       base_q;
    logic [2:0]       rows_left_q;
    logic [ColW-1:0]  col_cnt_q;
    logic [GrpW-1:0]  group_cnt_q;

    logic [7:0] store [5][RowBytes];

    logic        tready_q, tready_d;
    logic [71:0] wdata_q, wdata_d;
    logic        wdata_valid_q, wdata_valid_d;
    logic [23:0] pdata_q [5];
    logic [23:0] pdata_d [5];
    logic        pdata_valid_q, pdata_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_q, err_d;

    logic             acc, final_beat, early_last, row_done, last_col, last_grp;
    logic [ByteW-1:0] col0, col1, col2;
    logic [2:0]       rd_slot;
    logic             unused_keep;

    function automatic logic [2:0] slot_add(input logic [2:0] s, input logic [2:0] n);
        logic [3:0] t;
        t = {1'b0, s} + {1'b0, n};
        return (t >= 4'd5) ? 3'(t - 4'd5) : t[2:0];
    endfunction

    assign unused_keep = ^s_axis_tkeep;

    assign acc        = s_axis_tvalid & tready_q;
    assign row_done   = (beat_cnt_q == BeatW'(ROW_BEATS - 1));
    assign last_col   = (col_cnt_q == ColW'(COLS - 1));
    assign last_grp   = (group_cnt_q == GrpW'(GROUPS - 1));
    // Only the closing beat of the final image row may carry tlast.
    assign final_beat = (state_q == StRowLoad) && last_grp && (rows_left_q == 3'd1) && row_done;
    assign early_last = acc & s_axis_tlast & ~final_beat;

    assign col0 = ByteW'(col_cnt_q);
    assign col1 = col0 + ByteW'(1);
    assign col2 = col0 + ByteW'(2);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StWLoad;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWLoad: begin
                if (acc && !early_last && wcnt_q == 2'd2) state_d = StRowLoad;
            end
            StRowLoad: begin
                if (early_last) begin
                    state_d = StWLoad;
                end else if (acc && row_done && rows_left_q == 3'd1) begin
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (last_col) state_d = last_grp ? StFinish : StRowLoad;
            end
            StFinish: state_d = StWLoad;
            default:  state_d = StWLoad;
        endcase
    end

    always_comb begin
        wdata_d       = wdata_q;
        wdata_valid_d = 1'b0;
        if (state_q == StWLoad && acc && !early_last && wcnt_q == 2'd2) begin
            wdata_d       = {wbuf_q, s_axis_tdata[7:0]};
            wdata_valid_d = 1'b1;
        end
        pdata_valid_d = (state_q == StEmit);
        rd_slot       = '0;
        for (int n = 0; n < 5; n++) begin
            pdata_d[n] = pdata_q[n];
            if (state_q == StEmit) begin
                rd_slot    = slot_add(base_q, 3'(n));
                pdata_d[n] = {store[rd_slot][col0], store[rd_slot][col1], store[rd_slot][col2]};
            end
        end
        frame_done_d = (state_q == StFinish);
        // Ready returns one cycle after EMIT so it never overlaps the last pixel beat.
        tready_d = (state_d == StWLoad || state_d == StRowLoad) && (state_q != StEmit);
        err_d    = err_q | early_last | (acc & final_beat & ~s_axis_tlast);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tready_q      <= 1'b0;
            wdata_q       <= '0;
            wdata_valid_q <= 1'b0;
            for (int n = 0; n < 5; n++) pdata_q[n] <= '0;
            pdata_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            tready_q      <= tready_d;
            wdata_q       <= wdata_d;
            wdata_valid_q <= wdata_valid_d;
            for (int n = 0; n < 5; n++) pdata_q[n] <= pdata_d[n];
            pdata_valid_q <= pdata_valid_d;
            frame_done_q  <= frame_done_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || early_last) begin
            wcnt_q      <= '0;
            wbuf_q      <= '0;
            beat_cnt_q  <= '0;
            wr_slot_q   <= '0;
            base_q      <= '0;
            rows_left_q <= '0;
            col_cnt_q   <= '0;
            group_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StWLoad: begin
                    if (acc) begin
                        wcnt_q <= (wcnt_q == 2'd2) ? 2'd0 : wcnt_q + 2'd1;
                        if (wcnt_q == 2'd0) begin
                            wbuf_q[63:32] <= {s_axis_tdata[7:0], s_axis_tdata[15:8],
                                              s_axis_tdata[23:16], s_axis_tdata[31:24]};
                        end
                        if (wcnt_q == 2'd1) begin
                            wbuf_q[31:0] <= {s_axis_tdata[7:0], s_axis_tdata[15:8],
                                             s_axis_tdata[23:16], s_axis_tdata[31:24]};
                        end
                        if (wcnt_q == 2'd2) rows_left_q <= 3'd5;
                    end
                end
                StRowLoad: begin
                    if (acc) begin
                        if (row_done) begin
                            beat_cnt_q  <= '0;
                            wr_slot_q   <= slot_add(wr_slot_q, 3'd1);
                            rows_left_q <= rows_left_q - 3'd1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BeatW'(1);
                        end
                    end
                end
                StEmit: begin
                    if (last_col) begin
                        col_cnt_q <= '0;
                        if (last_grp) begin
                            group_cnt_q <= '0;
                            base_q      <= '0;
                            wr_slot_q   <= '0;
                        end else begin
                            group_cnt_q <= group_cnt_q + GrpW'(1);
                            base_q      <= slot_add(base_q, 3'd3);
                            rows_left_q <= 3'd3;
                        end
                    end else begin
                        col_cnt_q <= col_cnt_q + ColW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Line store has no reset; contents are always rewritten before use.
    always_ff @(posedge clk) begin
        if (state_q == StRowLoad && acc && !early_last) begin
            for (int i = 0; i < 4; i++) begin
                store[wr_slot_q][{beat_cnt_q, 2'(i)}] <= s_axis_tdata[8*i +: 8];
            end
        end
    end

    assign s_axis_tready = tready_q;
    assign wdata         = wdata_q;
    assign wdata_valid   = wdata_valid_q;
    assign pdata1        = pdata_q[0];
    assign pdata2        = pdata_q[1];
    assign pdata3        = pdata_q[2];
    assign pdata4        = pdata_q[3];
    assign pdata5        = pdata_q[4];
    assign pdata_valid   = pdata_valid_q;
    assign frame_done    = frame_done_q;
    assign err           = err_q;

endmodule
